// File: rtl/tdc_measure_engine.sv
// tdc_measure_engine: start/stop TDC measurement FSM with coarse counter and fine thermometer encoding.
//   Ports: clk, rst_n (async active-low), arm, start_hit, stop_hit, start_thermo[NTAPS],
//   stop_thermo[NTAPS], meas_ready -> meas_valid, fine_start[FINE_W], fine_stop[FINE_W],
//   coarse[COARSE_W], overflow, busy.
//   Define TDC_BUBBLE_CORRECT_EN for population-count fine encoding (bubble tolerant).
module tdc_measure_engine #(
  parameter int NTAPS = 8,
  parameter int COARSE_W = 4,
  localparam int FINE_W = $clog2(NTAPS) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arm,
  input  logic                start_hit,
  input  logic                stop_hit,
  input  logic [NTAPS-1:0]    start_thermo,
  input  logic [NTAPS-1:0]    stop_thermo,
  input  logic                meas_ready,
  output logic                meas_valid,
  output logic [FINE_W-1:0]   fine_start,
  output logic [FINE_W-1:0]   fine_stop,
  output logic [COARSE_W-1:0] coarse,
  output logic                overflow,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, ARMED, COUNT, DONE} state_t;
  state_t state_q, state_d;
  logic [COARSE_W-1:0] cnt_q, cnt_d, coarse_q, coarse_d;
  logic [FINE_W-1:0] fine_start_q, fine_start_d, fine_stop_q, fine_stop_d;
  logic overflow_q, overflow_d, start_prev_q, stop_prev_q;
  logic start_edge, stop_edge, cnt_max;
  function automatic logic [FINE_W-1:0] enc(input logic [NTAPS-1:0] t);
    logic [FINE_W-1:0] r;
    r = '0;
`ifdef TDC_BUBBLE_CORRECT_EN
    for (int i = 0; i < NTAPS; i++) r = r + FINE_W'(t[i]);
`else
    for (int i = 0; i < NTAPS; i++) if (t[i]) r = FINE_W'(i + 1);
`endif
    return r;
  endfunction
  assign start_edge = start_hit & ~start_prev_q;
  assign stop_edge = stop_hit & ~stop_prev_q;
  assign cnt_max = &cnt_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    coarse_d = coarse_q;
    fine_start_d = fine_start_q;
    fine_stop_d = fine_stop_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: state_d = arm ? ARMED : IDLE;
      ARMED: begin
        if (!arm) state_d = IDLE;
        else if (start_edge) begin
          fine_start_d = enc(start_thermo);
          cnt_d = '0;
          state_d = COUNT;
          if (stop_edge) begin
            fine_stop_d = enc(stop_thermo);
            coarse_d = '0;
            state_d = DONE;
          end
        end
      end
      COUNT: begin
        cnt_d = cnt_q + 1'b1;
        // A stop on the final count still reports its fine code, but saturates coarse.
        if (stop_edge) begin
          fine_stop_d = enc(stop_thermo);
          coarse_d = cnt_max ? '1 : cnt_q + 1'b1;
          overflow_d = cnt_max;
          state_d = DONE;
        end else if (cnt_max) begin
          fine_stop_d = '0;
          coarse_d = '1;
          overflow_d = 1'b1;
          state_d = DONE;
        end
      end
      default: if (meas_ready) begin
        overflow_d = 1'b0;
        state_d = arm ? ARMED : IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      coarse_q <= '0;
      fine_start_q <= '0;
      fine_stop_q <= '0;
      overflow_q <= 1'b0;
      start_prev_q <= 1'b0;
      stop_prev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      coarse_q <= coarse_d;
      fine_start_q <= fine_start_d;
      fine_stop_q <= fine_stop_d;
      overflow_q <= overflow_d;
      start_prev_q <= start_hit;
      stop_prev_q <= stop_hit;
    end
  end
  assign meas_valid = state_q == DONE;
  assign busy = state_q == COUNT;
  assign fine_start = fine_start_q;
  assign fine_stop = fine_stop_q;
  assign coarse = coarse_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_tdc_measure_engine.sv
// tb_tdc_measure_engine: directed table-driven bench for tdc_measure_engine (NTAPS=8, COARSE_W=4).
module tb_tdc_measure_engine;
  logic clk = 1'b0, rst_n, arm, start_hit, stop_hit, meas_ready;
  logic [7:0] start_thermo, stop_thermo;
  logic meas_valid, overflow, busy;
  logic [3:0] fine_start, fine_stop, coarse;
  int vectors = 0, fails = 0;
  typedef struct {
    logic [7:0] st;
    logic [7:0] sp;
    int n;
    logic [3:0] efs;
    logic [3:0] efe;
    logic [3:0] ec;
    logic eo;
  } vec_t;
  vec_t vec[8];
  tdc_measure_engine #(.NTAPS(8), .COARSE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .start_hit(start_hit), .stop_hit(stop_hit),
    .start_thermo(start_thermo), .stop_thermo(stop_thermo), .meas_ready(meas_ready),
    .meas_valid(meas_valid), .fine_start(fine_start), .fine_stop(fine_stop),
    .coarse(coarse), .overflow(overflow), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    arm = 1'b1;
    start_hit = 1'b0;
    stop_hit = 1'b0;
    meas_ready = 1'b0;
    @(negedge clk);
    start_hit = 1'b1;
    start_thermo = v.st;
    if (v.n == 0) begin
      stop_hit = 1'b1;
      stop_thermo = v.sp;
    end
    for (int k = 1; k <= v.n; k++) begin
      @(negedge clk);
      start_hit = 1'b0;
      if (k == v.n) begin
        stop_hit = 1'b1;
        stop_thermo = v.sp;
        chk("valid_before_capture", meas_valid, 0);
      end
    end
    @(negedge clk);
    start_hit = 1'b0;
    stop_hit = 1'b0;
    chk("meas_valid", meas_valid, 1);
    chk("fine_start", fine_start, v.efs);
    chk("fine_stop", fine_stop, v.efe);
    chk("coarse", coarse, v.ec);
    chk("overflow", overflow, v.eo);
    meas_ready = 1'b1;
    @(negedge clk);
    meas_ready = 1'b0;
    chk("valid_after_handshake", meas_valid, 0);
    chk("overflow_after_handshake", overflow, 0);
  endtask
  initial begin
    vec[0] = '{8'b00000111, 8'b00111111, 5, 4'd3, 4'd6, 4'd5, 1'b0};
    vec[1] = '{8'b00000001, 8'b01111111, 0, 4'd1, 4'd7, 4'd0, 1'b0};
    vec[2] = '{8'b00000000, 8'b11111111, 1, 4'd0, 4'd8, 4'd1, 1'b0};
    vec[3] = '{8'b11111111, 8'b00000001, 14, 4'd8, 4'd1, 4'd14, 1'b0};
    vec[4] = '{8'b00001111, 8'b00000011, 15, 4'd4, 4'd2, 4'd15, 1'b0};
    vec[5] = '{8'b00011111, 8'b00000111, 16, 4'd5, 4'd3, 4'd15, 1'b1};
`ifdef TDC_BUBBLE_CORRECT_EN
    vec[6] = '{8'b00101111, 8'b00000001, 2, 4'd5, 4'd1, 4'd2, 1'b0};
`else
    vec[6] = '{8'b00101111, 8'b00000001, 2, 4'd6, 4'd1, 4'd2, 1'b0};
`endif
    vec[7] = '{8'b00000000, 8'b00000000, 3, 4'd0, 4'd0, 4'd3, 1'b0};
    rst_n = 1'b0;
    arm = 1'b0;
    start_hit = 1'b0;
    stop_hit = 1'b0;
    meas_ready = 1'b0;
    start_thermo = '0;
    stop_thermo = '0;
    #1;
    chk("reset_outputs", {meas_valid, busy, overflow, coarse, fine_stop, fine_start}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) run_vec(vec[i]);
    // Overflow with no stop, then DONE held against stray stops.
    @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    start_hit = 1'b1;
    start_thermo = 8'b00000011;
    repeat (16) begin
      @(negedge clk);
      start_hit = 1'b0;
    end
    chk("ovf_still_counting", {busy, meas_valid}, 2'b10);
    @(negedge clk);
    chk("ovf_done", {meas_valid, overflow, coarse, fine_stop, fine_start}, {1'b1, 1'b1, 4'd15, 4'd0, 4'd2});
    for (int i = 0; i < 10; i++) begin
      stop_hit = (i % 2) == 0;
      stop_thermo = 8'hff;
      @(negedge clk);
      chk("done_hold", {meas_valid, overflow, coarse, fine_stop, fine_start}, {1'b1, 1'b1, 4'd15, 4'd0, 4'd2});
    end
    stop_hit = 1'b0;
    arm = 1'b0;
    meas_ready = 1'b1;
    @(negedge clk);
    meas_ready = 1'b0;
    chk("to_idle", {meas_valid, overflow, busy}, 0);
    start_hit = 1'b1;
    @(negedge clk);
    start_hit = 1'b0;
    @(negedge clk);
    chk("idle_ignores_start", {busy, meas_valid}, 0);
    arm = 1'b1;
    @(negedge clk);
    stop_hit = 1'b1;
    @(negedge clk);
    stop_hit = 1'b0;
    @(negedge clk);
    chk("armed_ignores_stop", {busy, meas_valid}, 0);
    // Reset in the middle of COUNT with the start hit held across release.
    start_hit = 1'b1;
    start_thermo = 8'b00000001;
    @(negedge clk);
    start_hit = 1'b0;
    repeat (3) @(negedge clk);
    chk("counting_before_reset", busy, 1);
    #2;
    rst_n = 1'b0;
    start_hit = 1'b1;
    #1;
    chk("async_reset_outputs", {meas_valid, busy, overflow, coarse, fine_stop, fine_start}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("held_hit_no_start", {busy, meas_valid}, 0);
    run_vec(vec[0]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
